// File: rtl/mem_cache.sv
// mem_cache: direct-mapped write-through cache between Processor and Memory; define CACHE_STATS_EN to add hit/miss counters
module mem_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [23:0] cpuAddr,
  input  logic        cpuLength,
  input  logic        cpuRd,
  input  logic        cpuWr,
  input  logic        cpuEnable,
  output logic        cpuRdy,
  input  logic [31:0] cpuDataIn,
  output logic [31:0] cpuDataOut,
  output logic [23:0] memAddr,
  output logic        memLength,
  output logic        memRd,
  output logic        memWr,
  output logic        memEnable,
  input  logic        memRdy,
  output logic [31:0] memDataOut,
  input  logic [31:0] memDataIn
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hitCount,
  output logic [15:0] missCount
`endif
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_BITS = 22 - INDEX_BITS;
  localparam logic [1:0] IDLE = 2'd0, MISS = 2'd1, WRITE = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic [23:0] reqAddr;
  logic reqLength;
  logic [31:0] reqData;
  logic reqHit;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0] lines [LINES];
  logic [INDEX_BITS-1:0] cpuIdx, reqIdx;
  logic [TAG_BITS-1:0] cpuTag;
  logic cpuHit;
  assign cpuIdx = cpuAddr[INDEX_BITS+1:2];
  assign reqIdx = reqAddr[INDEX_BITS+1:2];
  assign cpuTag = cpuAddr[23:INDEX_BITS+2];
  assign cpuHit = valid[cpuIdx] && tags[cpuIdx] == cpuTag;
  function automatic logic [31:0] pick(input logic [31:0] w, input logic [1:0] lane, input logic len);
    return len ? w : {24'd0, w[8*lane +: 8]};
  endfunction
  // memory request and completion pulse decoded from the current state
  always_comb begin
    memEnable = state == MISS || state == WRITE;
    memRd = state == MISS;
    memWr = state == WRITE;
    memLength = state == MISS || (state == WRITE && reqLength);
    memAddr = state == MISS ? {reqAddr[23:2], 2'b00} : state == WRITE ? reqAddr : '0;
    memDataOut = state == WRITE ? reqData : '0;
    cpuRdy = state == RESP;
  end
  // request sequencing, valid bits, read data and statistics
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      valid <= '0;
      cpuDataOut <= '0;
      reqAddr <= '0;
      reqLength <= 1'b0;
      reqData <= '0;
      reqHit <= 1'b0;
`ifdef CACHE_STATS_EN
      hitCount <= '0;
      missCount <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (cpuEnable) begin
          reqAddr <= cpuAddr;
          reqLength <= cpuLength;
          reqData <= cpuDataIn;
          reqHit <= cpuHit;
          state <= cpuWr ? WRITE : cpuRd && !cpuHit ? MISS : RESP;
          if (!cpuWr && cpuRd && cpuHit) cpuDataOut <= pick(lines[cpuIdx], cpuAddr[1:0], cpuLength);
`ifdef CACHE_STATS_EN
          if (!cpuWr && cpuRd && cpuHit && hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
          if (!cpuWr && cpuRd && !cpuHit && missCount != 16'hFFFF) missCount <= missCount + 16'd1;
`endif
        end
        MISS: if (memRdy) begin
          valid[reqIdx] <= 1'b1;
          cpuDataOut <= pick(memDataIn, reqAddr[1:0], reqLength);
          state <= RESP;
        end
        WRITE: if (memRdy) state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end
  // line data and tag storage: fill on miss completion, merge on write hit
  always_ff @(posedge Clk) begin
    if (Reset && state == MISS && memRdy) begin
      lines[reqIdx] <= memDataIn;
      tags[reqIdx] <= reqAddr[23:INDEX_BITS+2];
    end
    if (Reset && state == WRITE && memRdy && reqHit) begin
      if (reqLength) lines[reqIdx] <= reqData;
      else lines[reqIdx][8*reqAddr[1:0] +: 8] <= reqData[7:0];
    end
  end
endmodule

// File: doc/mem_cache.md
Name: mem_cache

Overview:
- Direct-mapped, write-through, one-word-per-line cache placed between Processor and Memory in Computer.
- Processor-side port set mirrors the Memory handshake (Addr, Length, Rd, Wr, Enable, Rdy, data both ways), so it drops into the existing Processor-Memory path unchanged.
- Read hits complete without a Memory access. Misses fill the line with one word read. Writes always go through to Memory and update the line on a hit.

Parameters:
- INDEX_BITS, 3, log2 of line count (8 lines, 32-bit data each). Index = cpuAddr[INDEX_BITS+1:2]; tag = cpuAddr[23:INDEX_BITS+2].

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- cpuAddr  in  24  byte address from Processor
- cpuLength  in  1  0 = byte access, 1 = 32-bit word access (word requires cpuAddr[1:0]=00)
- cpuRd  in  1  read request
- cpuWr  in  1  write request
- cpuEnable  in  1  request valid; held with all cpu* inputs until cpuRdy
- cpuRdy  out  1  one-cycle completion pulse
- cpuDataIn  in  32  write data; byte writes use [7:0]
- cpuDataOut  out  32  read data; byte reads zero-extended in [7:0]
- memAddr  out  24  address to Memory
- memLength  out  1  length to Memory
- memRd  out  1  read to Memory
- memWr  out  1  write to Memory
- memEnable  out  1  request to Memory; held until memRdy
- memRdy  in  1  Memory completion
- memDataOut  out  32  write data to Memory
- memDataIn  in  32  read data from Memory

Behaviour:
- Reset (Reset=0 at a rising edge):
  - State returns to IDLE; all valid bits cleared.
  - cpuRdy, memEnable, memRd, memWr, memLength = 0; cpuDataOut, memAddr, memDataOut = 0.
  - Reset during MISS or WRITE aborts the operation: memEnable=0 from that edge, and no cpuRdy is issued for the aborted request.
- States:
  - IDLE: at an edge with cpuEnable=1, latch request fields and go to:
    - WRITE if cpuWr=1 (Wr wins if Rd=Wr=1).
    - RESP if cpuRd=1 and hit (valid and tag equal); cpuDataOut loaded at that same edge.
    - MISS if cpuRd=1 and no hit.
    - RESP with no action if Rd=Wr=0.
  - MISS:
    - Drive memEnable=1, memRd=1, memLength=1, memAddr={addr[23:2],2'b00}.
    - On an edge with memRdy=1: write memDataIn, tag and valid into the line; load cpuDataOut; drop mem* request; go to RESP.
  - WRITE:
    - Drive memEnable=1, memWr=1, and memAddr/memLength/memDataOut = latched cpu values.
    - On an edge with memRdy=1: if hit, merge into the line (word replaces; byte replaces lane addr[1:0], bits [8*k+7:8*k]); on miss, no allocate. Go to RESP.
  - RESP: cpuRdy=1 for exactly this cycle, then unconditionally IDLE. cpuEnable sampled at the RESP-ending edge is ignored.
- Latency, from the accepting edge to cpuRdy high:
  - Read hit: 1 cycle.
  - Miss or write: memory latency + 1.
- Byte lane: little-endian; lane k = addr[1:0] occupies bits [8k+7:8k].
- cpuDataOut holds its value until the next read completes.
- Hit is evaluated at acceptance time only. Only one request is outstanding at a time.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds outputs hitCount (16, out) and missCount (16, out).
  - Read hit increments hitCount; read miss increments missCount; writes are not counted.
  - Each counter saturates at 0xFFFF and clears on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then read word 0x000010 while Memory answers 0xDEADBEEF after 3 cycles -> memEnable=memRd=memLength=1 with memAddr=0x000010; cpuRdy pulses one cycle after memRdy; cpuDataOut=0xDEADBEEF.
- Repeat read word 0x000010 -> cpuRdy 1 cycle after acceptance, memEnable stays 0, cpuDataOut=0xDEADBEEF.
- Byte read 0x000013 -> hit, cpuDataOut=0x000000DE, no Memory access.
- Byte write 0x000011 with data 0x55 -> Memory sees memWr=1, memLength=0, memAddr=0x000011, memDataOut[7:0]=0x55; then word read 0x000010 hits and returns 0xDEAD55EF.
- Read 0x000030 (same index 4, different tag) -> miss, fill; then read 0x000010 -> miss again, memEnable=1.
- Assert Reset=0 during a MISS wait -> memEnable=0 after that edge, no cpuRdy; after release, read 0x000010 misses. With CACHE_STATS_EN, counters read 0 after reset.
